// File: rtl/wb_dram_tester.sv
// wb_dram_tester
//   Wishbone classic master that writes a seeded pseudo-random pattern over
//   an address range, reads it back and compares. Used for DRAM bring-up.
//
//   Optional build macro: WB_TESTER_LOOP_EN adds loop_i / iter_count_o for
//   continuous write/read iterations with fresh data on each pass.
//
// Ports
//   user_clk_i, rst_n (async, active-low)
//   start_i            single-cycle start (accepted in IDLE/DONE only)
//   base_addr_i        first byte address      (latched at start)
//   num_words_i        words per pass          (latched at start)
//   seed_i             LFSR seed, 0 -> 1       (latched at start)
//   cyc_o/stb_o/we_o/addr_o/data_o, data_i/ack_i   Wishbone master side
//   busy_o             test in progress
//   done_o             sticky completion flag
//   pass_o             result, valid with done_o
//   err_count_o        saturating mismatch count
//   first_err_addr_o   address of first mismatching word
//   timeout_o          sticky abort flag (slave failed to ack)
module wb_dram_tester #(
  parameter int unsigned WORD_SIZE      = 128,
  parameter int unsigned ADDR_STRIDE    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                 user_clk_i,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [31:0]          base_addr_i,
  input  logic [15:0]          num_words_i,
  input  logic [31:0]          seed_i,
`ifdef WB_TESTER_LOOP_EN
  input  logic                 loop_i,
  output logic [31:0]          iter_count_o,
`endif
  output logic                 cyc_o,
  output logic                 stb_o,
  output logic                 we_o,
  output logic [31:0]          addr_o,
  output logic [WORD_SIZE-1:0] data_o,
  input  logic [WORD_SIZE-1:0] data_i,
  input  logic                 ack_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [15:0]          err_count_o,
  output logic [31:0]          first_err_addr_o,
  output logic                 timeout_o
);

  localparam int unsigned LANES = WORD_SIZE / 32;
  localparam logic [31:0] POLY  = 32'h8020_0003;

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE
  } state_t;

  state_t state, state_nx;

  logic [31:0]          base_r, seed_r, lfsr, addr_r, wait_cnt;
  logic [15:0]          num_r, k;
  logic [15:0]          err_cnt;
  logic [31:0]          first_err;
  logic                 timeout_r, done_r, pass_r;
  logic [WORD_SIZE-1:0] exp_word;
  logic [31:0]          lfsr_adv;
  logic                 start_ok, last_word, wait_expired, mismatch, loop_again;

  assign start_ok     = start_i && ((state == IDLE) || (state == DONE));
  assign last_word    = (k == (num_r - 16'd1));
  assign wait_expired = (wait_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign lfsr_adv     = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? POLY : '0);
  assign mismatch     = (data_i != exp_word);

`ifdef WB_TESTER_LOOP_EN
  assign loop_again = loop_i;
`else
  assign loop_again = 1'b0;
`endif

  always_comb begin
    exp_word = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      exp_word[j*32 +: 32] = lfsr ^ j;
    end
  end

  always_ff @(posedge user_clk_i or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start_ok) state_nx = (num_words_i == '0) ? DONE : WR_REQ;
      WR_REQ:     if (ack_i) state_nx = WR_GAP;
                  else if (wait_expired) state_nx = DONE;
      WR_GAP:     state_nx = last_word ? RD_REQ : WR_REQ;
      RD_REQ:     if (ack_i) state_nx = RD_GAP;
                  else if (wait_expired) state_nx = DONE;
      RD_GAP:     if (!last_word) state_nx = RD_REQ;
                  else state_nx = loop_again ? WR_REQ : DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge user_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      base_r    <= '0;
      num_r     <= '0;
      seed_r    <= '0;
      lfsr      <= '0;
      k         <= '0;
      addr_r    <= '0;
      wait_cnt  <= '0;
      err_cnt   <= '0;
      first_err <= '0;
      timeout_r <= 1'b0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
`ifdef WB_TESTER_LOOP_EN
      iter_count_o <= '0;
`endif
    end else if (start_ok) begin
      base_r    <= base_addr_i;
      num_r     <= num_words_i;
      seed_r    <= (seed_i == '0) ? 32'd1 : seed_i;
      lfsr      <= (seed_i == '0) ? 32'd1 : seed_i;
      k         <= '0;
      addr_r    <= base_addr_i;
      wait_cnt  <= '0;
      err_cnt   <= '0;
      first_err <= '0;
      timeout_r <= 1'b0;
      // A zero-length test completes immediately as a pass.
      done_r    <= (num_words_i == '0);
      pass_r    <= (num_words_i == '0);
    end else begin
      case (state)
        WR_REQ, RD_REQ: begin
          if (ack_i) begin
            wait_cnt <= '0;
            if ((state == RD_REQ) && mismatch) begin
              if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
              if (err_cnt == '0)       first_err <= addr_r;
            end
          end else if (wait_expired) begin
            // addr_r is left untouched so the stuck address stays visible.
            timeout_r <= 1'b1;
            done_r    <= 1'b1;
            pass_r    <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        WR_GAP, RD_GAP: begin
          wait_cnt <= '0;
          if (last_word) begin
            k      <= '0;
            addr_r <= base_r;
            lfsr   <= seed_r;
            if (state == RD_GAP) begin
              if (loop_again) begin
                // Next iteration continues the LFSR sequence so data differs.
                seed_r <= lfsr_adv;
                lfsr   <= lfsr_adv;
`ifdef WB_TESTER_LOOP_EN
                iter_count_o <= iter_count_o + 32'd1;
`endif
              end else begin
                done_r <= 1'b1;
                pass_r <= (err_cnt == '0) && !timeout_r;
              end
            end
          end else begin
            k      <= k + 16'd1;
            addr_r <= addr_r + 32'(ADDR_STRIDE);
            lfsr   <= lfsr_adv;
          end
        end
        default: ;
      endcase
    end
  end

  assign cyc_o            = (state == WR_REQ) || (state == RD_REQ);
  assign stb_o            = cyc_o;
  assign we_o             = (state == WR_REQ);
  assign addr_o           = addr_r;
  assign data_o           = (state == WR_REQ) ? exp_word : '0;
  assign busy_o           = (state != IDLE) && (state != DONE);
  assign done_o           = done_r;
  assign pass_o           = pass_r;
  assign err_count_o      = err_cnt;
  assign first_err_addr_o = first_err;
  assign timeout_o        = timeout_r;

endmodule

// File: tb/tb_wb_dram_tester.sv
module tb_wb_dram_tester;
  localparam int WS = 128;

  logic          user_clk_i = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [31:0]   base_addr_i = '0;
  logic [15:0]   num_words_i = '0;
  logic [31:0]   seed_i = '0;
  logic          cyc_o, stb_o, we_o;
  logic [31:0]   addr_o;
  logic [WS-1:0] data_o;
  logic [WS-1:0] data_i = '0;
  logic          ack_i = 1'b0;
  logic          busy_o, done_o, pass_o, timeout_o;
  logic [15:0]   err_count_o;
  logic [31:0]   first_err_addr_o;

  wb_dram_tester #(.WORD_SIZE(WS), .ADDR_STRIDE(16), .TIMEOUT_CYCLES(16)) dut (
    .user_clk_i(user_clk_i), .rst_n(rst_n), .start_i(start_i),
    .base_addr_i(base_addr_i), .num_words_i(num_words_i), .seed_i(seed_i),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .addr_o(addr_o),
    .data_o(data_o), .data_i(data_i), .ack_i(ack_i), .busy_o(busy_o),
    .done_o(done_o), .pass_o(pass_o), .err_count_o(err_count_o),
    .first_err_addr_o(first_err_addr_o), .timeout_o(timeout_o)
  );

  always #5 user_clk_i = ~user_clk_i;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit            we;
    logic [31:0]   addr;
    logic [WS-1:0] data;
    int            t;
  } txn_t;

  txn_t          log_q[$];
  logic [WS-1:0] mem[logic [31:0]];
  bit            no_ack = 1'b0;
  bit            corrupt_en = 1'b0;
  logic [31:0]   corrupt_addr = '0;
  int            cyc_now = 0;
  int            cyc_hi = 0;
  int            cyc_rises = 0;
  int            wcnt = 0;
  logic          prev_cyc = 1'b0;

  always @(posedge user_clk_i) cyc_now++;

  // Slave memory model: acks on the second cycle of each request.
  always @(negedge user_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ack_i = 1'b0; wcnt = 0; prev_cyc = 1'b0;
    end else if (!user_clk_i) begin
      if (cyc_o && !prev_cyc) cyc_rises++;
      if (cyc_o) cyc_hi++;
      prev_cyc = cyc_o;
      if (ack_i) begin
        ack_i = 1'b0;
      end else if (cyc_o && stb_o && !no_ack) begin
        wcnt++;
        if (wcnt == 2) begin
          wcnt = 0;
          ack_i = 1'b1;
          if (we_o) begin
            mem[addr_o] = data_o;
            log_q.push_back('{1'b1, addr_o, data_o, cyc_now});
          end else begin
            data_i = mem.exists(addr_o) ? mem[addr_o] : '0;
            if (corrupt_en && addr_o == corrupt_addr) data_i[0] = ~data_i[0];
            log_q.push_back('{1'b0, addr_o, data_i, cyc_now});
          end
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [WS-1:0] pattern_word(input logic [31:0] p);
    logic [WS-1:0] w = '0;
    for (int j = 0; j < WS/32; j++) w[j*32 +: 32] = p ^ 32'(j);
    return w;
  endfunction

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [31:0] b, input logic [15:0] n, input logic [31:0] s);
    @(negedge user_clk_i);
    base_addr_i = b; num_words_i = n; seed_i = s; start_i = 1'b1;
    @(negedge user_clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_o) begin ok = 1'b1; break; end
      @(negedge user_clk_i);
    end
  endtask

  // Runs a full test and compares the bus log and result flags with the model.
  task automatic run_pass(input string tag, input logic [31:0] b, input logic [15:0] n,
                          input logic [31:0] s, input bit cen, input logic [31:0] caddr,
                          input bit poke_busy, output int idx0);
    bit ok;
    logic [31:0] p, a, exp_first;
    int exp_err;
    corrupt_en = cen; corrupt_addr = caddr;
    idx0 = log_q.size();
    pulse_start(b, n, s);
    check({tag, "_start_clr"}, {done_o, pass_o, timeout_o, err_count_o}, '0);
    if (poke_busy) begin
      base_addr_i = 32'h5000; num_words_i = 16'd1; start_i = 1'b1;
      @(negedge user_clk_i);
      start_i = 1'b0;
    end
    wait_done(40 * int'(n) + 40, ok);
    check({tag, "_done"}, ok, 1'b1);
    check({tag, "_count"}, log_q.size() - idx0, 2 * int'(n));
    exp_err = 0; exp_first = '0;
    for (int pass_i = 0; pass_i < 2; pass_i++) begin
      p = (s == 0) ? 32'd1 : s;
      for (int k = 0; k < int'(n); k++) begin
        logic [WS-1:0] d;
        int li;
        a = b + 32'(k) * 32'd16;
        d = pattern_word(p);
        if (pass_i == 1 && cen && a == caddr) begin
          d[0] = ~d[0];
          if (exp_err == 0) exp_first = a;
          exp_err++;
        end
        li = idx0 + pass_i * int'(n) + k;
        if (li < log_q.size())
          check($sformatf("%s_txn%0d", tag, pass_i * int'(n) + k),
                {log_q[li].we, log_q[li].addr, log_q[li].data},
                {pass_i == 0, a, d});
        p = lfsr_next(p);
      end
    end
    check({tag, "_err"}, err_count_o, exp_err);
    check({tag, "_first"}, first_err_addr_o, exp_first);
    check({tag, "_flags"}, {done_o, pass_o, timeout_o, busy_o}, {1'b1, exp_err == 0, 2'b00});
    corrupt_en = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    bit ok;
    int hi0, r0;
    logic [31:0] rb, rs, ca;
    logic [15:0] rn;

    repeat (3) @(negedge user_clk_i);
    check("reset_outs", {cyc_o, stb_o, we_o, addr_o, data_o, busy_o, done_o, pass_o,
                         err_count_o, first_err_addr_o, timeout_o}, '0);
    rst_n = 1'b1;
    @(negedge user_clk_i);

    // Good memory, seed 1, with explicit pattern and spacing checks.
    run_pass("good", 32'h1000, 16'd4, 32'd1, 1'b0, '0, 1'b0, idx);
    check("w0_lanes", log_q[idx].data, {32'h2, 32'h3, 32'h0, 32'h1});
    check("w1_lane0", log_q[idx+1].data[31:0], 32'h8020_0003);
    for (int i = 1; i < 8; i++)
      check($sformatf("gap%0d", i), log_q[idx+i].t - log_q[idx+i-1].t, 3);

    // Single flipped bit at 0x1020.
    run_pass("corrupt", 32'h1000, 16'd4, 32'd1, 1'b1, 32'h1020, 1'b0, idx);

    // Slave never acks.
    no_ack = 1'b1;
    hi0 = cyc_hi;
    pulse_start(32'h1000, 16'd4, 32'd1);
    wait_done(100, ok);
    check("to_done", ok, 1'b1);
    check("to_cyc_cycles", cyc_hi - hi0, 16);
    check("to_flags", {cyc_o, timeout_o, done_o, pass_o, busy_o}, 5'b01100);
    check("to_addr", addr_o, 32'h1000);
    no_ack = 1'b0;

    // Zero-length test.
    r0 = cyc_rises;
    pulse_start(32'h1000, 16'd0, 32'd7);
    @(negedge user_clk_i);
    check("zero_done", {done_o, pass_o, busy_o}, 3'b110);
    repeat (5) @(negedge user_clk_i);
    check("zero_nocyc", cyc_rises - r0, 0);

    // Address wrap and seed zero replacement.
    run_pass("wrap", 32'hFFFF_FFF0, 16'd2, $urandom, 1'b0, '0, 1'b0, idx);
    run_pass("seed0", 32'h2000, 16'd3, 32'd0, 1'b0, '0, 1'b0, idx);

    // Randomized runs.
    for (int r = 0; r < 3; r++) begin
      rb = $urandom;
      rn = 16'($urandom_range(1, 6));
      rs = $urandom;
      ca = rb + 32'($urandom_range(0, int'(rn) - 1)) * 32'd16;
      run_pass($sformatf("rand%0d", r), rb, rn, rs, 1'($urandom_range(0, 1)), ca, 1'b0, idx);
    end

    // Reset during the second write request.
    r0 = cyc_rises;
    pulse_start(32'h1000, 16'd4, 32'd5);
    for (int i = 0; i < 100 && cyc_rises < r0 + 2; i++) @(negedge user_clk_i);
    check("rst_reach_wr2", cyc_rises - r0, 2);
    #2 rst_n = 1'b0;
    #1 check("rst_async_outs", {cyc_o, stb_o, we_o, addr_o, data_o, busy_o, done_o, pass_o,
                                err_count_o, first_err_addr_o, timeout_o}, '0);
    @(negedge user_clk_i);
    rst_n = 1'b1;
    run_pass("restart", 32'h1000, 16'd4, 32'd1, 1'b0, '0, 1'b1, idx);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_dram_tester.md
Name: wb_dram_tester

Overview:
- Wishbone classic master (initiator) on user_clk_i. Drives the DRAM controller's Wishbone slave port.
- Writes a seeded pseudo-random pattern across an address range, reads it back and compares.
- Reports pass/fail, error count, first failing address and timeout.
- Used for board bring-up and regression of the DRAM path after calibration.

Parameters:
- WORD_SIZE, 128, data bus width; multiple of 32.
- ADDR_STRIDE, 16, byte increment between consecutive words.
- TIMEOUT_CYCLES, 4096, maximum cycles a request may wait for ack_i.

Ports:
- user_clk_i  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- start_i  in  1  single-cycle start pulse
- base_addr_i  in  32  first byte address; latched at start
- num_words_i  in  16  words per pass; latched at start
- seed_i  in  32  LFSR seed; latched at start (0 is replaced by 1)
- cyc_o  out  1  Wishbone cycle
- stb_o  out  1  Wishbone strobe
- we_o  out  1  1 = write
- addr_o  out  32  Wishbone address
- data_o  out  WORD_SIZE  write data
- data_i  in  WORD_SIZE  read data
- ack_i  in  1  Wishbone acknowledge
- busy_o  out  1  test in progress
- done_o  out  1  sticky until next accepted start
- pass_o  out  1  valid when done_o=1
- err_count_o  out  16  mismatching words; saturates at 0xFFFF
- first_err_addr_o  out  32  address of first mismatch
- timeout_o  out  1  sticky abort flag

Behaviour:
- Reset: every output 0. FSM enters IDLE.
- States: IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE.
- Start acceptance:
  - start_i is accepted only in IDLE or DONE. It is ignored while busy_o=1.
  - Accepting start clears done_o, pass_o, err_count_o, first_err_addr_o and timeout_o.
  - On start: latch inputs, set index k=0, load LFSR with the seed.
  - If num_words_i=0, go to DONE with pass_o=1 and never assert cyc_o.
  - Otherwise enter WR_REQ on the next cycle.
- Pattern generation:
  - pat_k is the Galois LFSR state, right-shifting: s' = (s>>1) ^ (s[0] ? 0x80200003 : 0).
  - pat_0 = seed. The LFSR advances once per word.
  - data word k: 32-bit lane j = pat_k ^ j, for j = 0..WORD_SIZE/32-1.
  - Read pass reloads the seed, so it regenerates the identical sequence.
- Addressing: addr_o = base + k*ADDR_STRIDE, modulo 2^32 (wraps).
- WR_REQ:
  - Drive cyc_o=stb_o=we_o=1 with addr_o and data_o.
  - Hold all signals stable until ack_i=1.
  - On the ack cycle go to WR_GAP.
- WR_GAP:
  - Drive cyc_o=stb_o=0 for exactly one cycle, so the slave leaves its ack state.
  - Increment k and advance the LFSR.
  - If k was the last word, reset k=0, reload the seed and go to RD_REQ; otherwise go to WR_REQ.
- RD_REQ:
  - Drive cyc_o=stb_o=1, we_o=0.
  - On ack_i=1, compare data_i with the expected word.
  - On mismatch, increment err_count_o (saturating). If it is the first mismatch, capture first_err_addr_o=addr_o.
  - Go to RD_GAP.
- RD_GAP: same as WR_GAP. After the last word go to DONE.
- DONE: busy_o=0, done_o=1, pass_o = (err_count_o==0 && !timeout_o).
- Timeout:
  - A wait counter is cleared on entry to each REQ state.
  - If it reaches TIMEOUT_CYCLES-1 without ack_i: drop cyc_o/stb_o next cycle, set timeout_o=1, and go to DONE with pass_o=0.
  - addr_o holds the stuck address.
- ack_i outside a REQ state is ignored.
- busy_o=1 in all states except IDLE and DONE.
- Reset asserted mid-operation aborts immediately and asynchronously; no state is retained.

Optional Feature:
- Macro: WB_TESTER_LOOP_EN.
- When defined, adds ports loop_i (in, 1) and iter_count_o (out, 32, reset 0).
  - At the end of the read pass, if loop_i=1 and no timeout: increment iter_count_o (wraps), reset k=0, and re-enter WR_REQ.
  - The new pass seeds from the current LFSR state, so each iteration uses new data.
  - err_count_o and first_err_addr_o accumulate across iterations.
  - Deasserting loop_i ends in DONE after the current read pass.
- When undefined, these ports are absent and the block performs a single write pass plus read pass.

Test Plan:
- Single pass, good memory: bench memory model with 2-cycle ack; base=0x1000, num=4, seed=1.
  - Response: 4 writes to 0x1000/0x1010/0x1020/0x1030.
  - Word0 lanes = 0x00000001, 0x00000000, 0x00000003, 0x00000002; word1 lane0 = 0x80200003.
  - One idle cycle between requests, then 4 reads; done=1, pass=1, err_count=0.
- Corrupted word: model flips bit 0 on read of 0x1020, same setup.
  - Response: err_count=1, first_err_addr=0x1020, pass=0.
- Timeout: slave never acks, TIMEOUT_CYCLES=16.
  - Response: cyc_o low after 16 cycles, timeout=1, done=1, pass=0, addr_o=0x1000.
- Zero words: num=0.
  - Response: cyc_o never asserted; done=1, pass=1 two cycles after start.
- Address wrap: base=0xFFFFFFF0, num=2.
  - Response: addresses 0xFFFFFFF0 then 0x00000000; pass=1.
- Reset mid-write: rst_n low during the second write.
  - Response: all outputs 0 immediately.
  - After release, start with base=0x1000 restarts from 0x1000; start_i pulsed while busy is ignored.
